// File: rtl/rom_burst_reader_if.sv
// rom_burst_reader_if: burst request, ROM port and output stream bundle for rom_burst_reader
interface rom_burst_reader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic                     start;
    logic [ADDR_W-1:0]        start_addr;
    logic [ADDR_W:0]          len;
    logic                     abort;
    logic [ADDR_W-1:0]        rom_addr;
    logic [DATA_W-1:0]        rom_data;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;
    logic                     done;
    logic [DATA_W+ADDR_W-1:0] sum;

    modport master (
        output start, start_addr, len, abort, rom_data, out_ready,
        input  rom_addr, out_data, out_valid, out_last, busy, done, sum
    );

    modport slave (
        input  start, start_addr, len, abort, rom_data, out_ready,
        output rom_addr, out_data, out_valid, out_last, busy, done, sum
    );
endinterface

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: walks ROM addresses for a burst and streams each word out through a one-deep registered slot
module rom_burst_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    rom_burst_reader_if.slave bus
);
    localparam int SUM_W = DATA_W + ADDR_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [ADDR_W:0] remaining;
    logic            accept, launch, capture, finish;

    assign accept  = bus.out_valid && bus.out_ready;
    assign launch  = (state == IDLE) && bus.start && !bus.abort;
    assign capture = (state == RUN) && (!bus.out_valid || bus.out_ready);
    assign finish  = (state == DRAIN) && accept && bus.out_last;
    assign bus.busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: abort wins, otherwise IDLE->RUN on a non-empty start, RUN->DRAIN on the final capture
    always_comb begin
        state_nxt = state;
        if (bus.abort) state_nxt = IDLE;
        else begin
            unique case (state)
                IDLE:    state_nxt = (launch && bus.len != '0) ? RUN : IDLE;
                RUN:     state_nxt = (capture && remaining == (ADDR_W+1)'(1)) ? DRAIN : RUN;
                DRAIN:   state_nxt = finish ? IDLE : DRAIN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: address walk, output slot, done pulse and running sum of accepted words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rom_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.done      <= 1'b0;
            bus.sum       <= '0;
            remaining     <= '0;
        end else if (bus.abort) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= finish || (launch && bus.len == '0);
            bus.sum  <= launch ? '0 : accept ? bus.sum + SUM_W'(bus.out_data) : bus.sum;
            if (launch && bus.len != '0) begin
                bus.rom_addr <= bus.start_addr;
                remaining    <= bus.len;
            end
            if (capture) begin
                bus.out_data  <= bus.rom_data;
                bus.out_valid <= 1'b1;
                bus.out_last  <= (remaining == (ADDR_W+1)'(1));
                bus.rom_addr  <= bus.rom_addr + ADDR_W'(1);
                remaining     <= remaining - (ADDR_W+1)'(1);
            end else if (accept) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: scoreboard bench for rom_burst_reader against a rom[i]=i+1 model
module tb_rom_burst_reader;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    logic [DATA_W:0]          exp_q[$];
    logic [DATA_W+ADDR_W-1:0] done_q[$];

    rom_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    assign bus.rom_data = DATA_W'(bus.rom_addr) + DATA_W'(1);

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input int a, input int n);
        int s;
        s = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.start_addr = ADDR_W'(a);
        bus.len = (ADDR_W+1)'(n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), DATA_W'(((a + i) % 16) + 1)});
            s += ((a + i) % 16) + 1;
        end
        done_q.push_back((DATA_W+ADDR_W)'(s));
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("wait_idle_timeout", ok, 1);
        @(posedge clk); #1;
    endtask

    // Monitor: pops expected words on every transfer, checks stall stability and done/sum
    initial begin
        logic [DATA_W:0] e;
        logic            prev_stall;
        logic [DATA_W:0] prev_word;
        prev_stall = 1'b0;
        prev_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall && bus.out_valid)
                check("stall_stable", {bus.out_last, bus.out_data}, prev_word);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_word", {bus.out_last, bus.out_data}, -1);
                else begin
                    e = exp_q.pop_front();
                    check("word_data", bus.out_data, e[DATA_W-1:0]);
                    check("word_last", bus.out_last, e[DATA_W]);
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) check("unexpected_done", bus.done, 0);
                else check("done_sum", bus.sum, done_q.pop_front());
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word = {bus.out_last, bus.out_data};
        end
    end

    initial begin
        logic [5:0] pat;
        bit         ok;
        pat = 6'b101001;
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.len = '0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rom_addr", bus.rom_addr, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        rst_n = 1'b1;

        do_start(0, 16);
        check("lat_valid_k", bus.out_valid, 0);
        check("lat_busy_k", bus.busy, 1);
        @(posedge clk); #1;
        check("lat_valid_k1", bus.out_valid, 1);
        check("lat_data_k1", bus.out_data, 1);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.start_addr = 4'd9;
        bus.len = 5'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();
        check("sum_full", bus.sum, 136);

        do_start(14, 4);
        check("wrap_addr_k", bus.rom_addr, 14);
        @(posedge clk); #1;
        check("wrap_addr_k1", bus.rom_addr, 15);
        @(posedge clk); #1;
        check("wrap_addr_k2", bus.rom_addr, 0);
        wait_idle();
        check("sum_wrap", bus.sum, 34);

        do_start(3, 5);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            bus.out_ready = pat[i % 6];
            if (!bus.busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("stall_timeout", ok, 1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("sum_stall", bus.sum, 30);

        do_start(7, 0);
        check("len0_done", bus.done, 1);
        check("len0_valid", bus.out_valid, 0);
        check("len0_busy", bus.busy, 0);
        check("len0_sum", bus.sum, 0);
        @(posedge clk); #1;
        check("len0_done_off", bus.done, 0);

        do_start(0, 8);
        repeat (3) @(posedge clk);
        #1;
        check("abort_pre_data", bus.out_data, 3);
        check("abort_pre_valid", bus.out_valid, 1);
        bus.abort = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        exp_q.delete();
        done_q.delete();
        check("abort_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_sum", bus.sum, 3);
        check("abort_done", bus.done, 0);
        @(posedge clk); #1;
        check("abort_done_later", bus.done, 0);
        bus.out_ready = 1'b1;
        do_start(5, 1);
        wait_idle();
        check("single_sum", bus.sum, 6);

        do_start(0, 8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_sum", bus.sum, 0);
        check("arst_rom_addr", bus.rom_addr, 0);
        exp_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        do_start(10, 3);
        wait_idle();
        check("post_rst_sum", bus.sum, 36);
        repeat (2) @(posedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
